// File: rtl/data_mem_copy_engine.sv
// Memory-to-memory copy engine with memmove semantics, placed in front of a
// single-port data memory and programmed through a 4-word CSR slave.
module data_mem_copy_engine #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);
    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(2**ADDR_W);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_t;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] src_cur_q, src_cur_d, dst_cur_q, dst_cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              desc_q, desc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              irq_en_q, irq_en_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              busy, ctrl_wr;
    logic [LEN_W:0]    src_end, dst_end, src_last, dst_last;

    wire unused_wdata = ^csr_writedata[31:LEN_W];

    // A start is held for one cycle in start_q; the range decision happens on
    // the following edge, so the engine counts as busy from the start edge on.
    assign busy     = (state_q != S_IDLE) || start_q;
    assign ctrl_wr  = csr_write && (csr_address == 2'd0);
    assign src_end  = (LEN_W+1)'(src_q) + (LEN_W+1)'(len_q);
    assign dst_end  = (LEN_W+1)'(dst_q) + (LEN_W+1)'(len_q);
    assign src_last = src_end - (LEN_W+1)'(1);
    assign dst_last = dst_end - (LEN_W+1)'(1);

    always_comb begin
        state_d        = state_q;
        start_d        = 1'b0;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        src_cur_d      = src_cur_q;
        dst_cur_d      = dst_cur_q;
        rem_d          = rem_q;
        desc_d         = desc_q;
        data_d         = data_q;
        done_d         = done_q;
        err_d          = err_q;
        irq_en_d       = irq_en_q;
        rdata_d        = rdata_q;
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        mem_clken      = 1'b0;

        if (csr_write && !busy) begin
            case (csr_address)
                2'd1:    src_d = csr_writedata[ADDR_W-1:0];
                2'd2:    dst_d = csr_writedata[ADDR_W-1:0];
                2'd3:    len_d = csr_writedata[LEN_W-1:0];
                default: ;
            endcase
        end

        if (ctrl_wr) begin
            irq_en_d = csr_writedata[3];
            if (csr_writedata[1]) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
            if (csr_writedata[0] && !busy) start_d = 1'b1;
        end

        if (csr_read) begin
            case (csr_address)
                2'd0:    rdata_d = {28'd0, irq_en_q, err_q, done_q, busy};
                2'd1:    rdata_d = 32'(src_q);
                2'd2:    rdata_d = 32'(dst_q);
                default: rdata_d = 32'(len_q);
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else if (src_end > DEPTH || dst_end > DEPTH) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                        rem_d   = len_q;
                        // Copy from the top down when the destination lies above
                        // the source so overlapping words are read before overwritten.
                        desc_d  = dst_q > src_q;
                        if (dst_q > src_q) begin
                            src_cur_d = src_last[ADDR_W-1:0];
                            dst_cur_d = dst_last[ADDR_W-1:0];
                        end else begin
                            src_cur_d = src_q;
                            dst_cur_d = dst_q;
                        end
                    end
                end
            end
            S_RD: begin
                mem_address    = src_cur_q;
                mem_chipselect = 1'b1;
                mem_clken      = 1'b1;
                state_d        = S_CAP;
            end
            S_CAP: begin
                data_d  = mem_readdata;
                state_d = S_WR;
            end
            S_WR: begin
                mem_address    = dst_cur_q;
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_writedata  = data_q;
                mem_clken      = 1'b1;
                src_cur_d      = desc_q ? src_cur_q - ADDR_W'(1) : src_cur_q + ADDR_W'(1);
                dst_cur_d      = desc_q ? dst_cur_q - ADDR_W'(1) : dst_cur_q + ADDR_W'(1);
                rem_d          = rem_q - LEN_W'(1);
                state_d        = (rem_q == LEN_W'(1)) ? S_FIN : S_RD;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a pending start decision.
        if (ctrl_wr && csr_writedata[2] && busy) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            src_cur_q <= '0;
            dst_cur_q <= '0;
            rem_q     <= '0;
            desc_q    <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            src_cur_q <= src_cur_d;
            dst_cur_q <= dst_cur_d;
            rem_q     <= rem_d;
            desc_q    <= desc_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            irq_en_q  <= irq_en_d;
            rdata_q   <= rdata_d;
        end
    end

    assign csr_readdata   = rdata_q;
    assign irq            = done_q & irq_en_q;
    assign mem_byteenable = 4'hF;

endmodule

// File: doc/data_mem_copy_engine.md
Name: data_mem_copy_engine

Overview:
- Memory-to-memory copy engine that sits directly upstream of the 8192 x 32 single-port on-chip data memory.
- Drives the memory's address/byteenable/chipselect/write/writedata/clken pins and consumes its readdata.
- A CPU programs source, destination and length through a 4-word Avalon-MM CSR slave. The engine then moves words inside the memory with memmove semantics and raises done/irq on completion.

Parameters:
- ADDR_W, 13, memory word-address width (depth = 2^ADDR_W = 8192)
- DATA_W, 32, memory data width
- LEN_W, 14, length field width (0..8192 words)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- csr_address  in  2  CSR word select (0 CTRL/STATUS, 1 SRC, 2 DST, 3 LEN)
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, registered, read latency 1
- irq  out  1  done & irq_en
- mem_address  out  13  memory word address
- mem_byteenable  out  4  always 4'b1111 when writing
- mem_chipselect  out  1  memory select
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  data written to memory
- mem_clken  out  1  memory clock enable
- mem_readdata  in  32  memory read data, valid the cycle after its address is presented

Behaviour:
- Reset (async): all outputs 0, except mem_byteenable = 4'hF. State IDLE; SRC/DST/LEN/flags = 0.
- CTRL write bits:
  - bit0 start (self-clearing)
  - bit1 clear_done (clears done and error)
  - bit2 abort
  - bit3 irq_en (stored)
- STATUS read bits: bit0 busy, bit1 done, bit2 error, bit3 irq_en.
- SRC read/write: 13 bits. DST read/write: 13 bits. LEN read/write: 14 bits.
- Writes to SRC/DST/LEN while busy are ignored.
- Start decision (evaluated on the start edge, from IDLE only; start while busy is ignored):
  - LEN = 0: done=1 next cycle, no memory access.
  - SRC+LEN > 8192 or DST+LEN > 8192: error=1, done=1, no memory access.
  - Otherwise busy=1.
    - Direction is descending when DST > SRC: cursors start at SRC+LEN-1 / DST+LEN-1 and decrement.
    - Otherwise ascending: cursors start at SRC / DST and increment.
- FSM IDLE -> RD -> CAP -> WR -> (RD | FIN) -> IDLE:
  - RD: mem_address = src cursor, chipselect=1, write=0, clken=1.
  - CAP: latch mem_readdata into data register; chipselect=0.
  - WR: mem_address = dst cursor, writedata = latched data, chipselect=1, write=1, clken=1. Then advance cursors and decrement remaining count; go to FIN if remaining reaches 0, else back to RD.
  - FIN: busy=0, done=1, return to IDLE.
- Timing: exactly 3 cycles per word. done is visible 3*LEN+2 cycles after the start write edge.
- Abort: any non-IDLE state goes to IDLE next edge.
  - busy=0, done=0, error=1.
  - A write already in WR that cycle completes; no further memory accesses.
- clear_done together with start in the same write: clear first, then start.
- mem_clken = 0 in IDLE/CAP/FIN. Cursors never wrap: the range check guarantees it.
- Reset mid-transfer: immediate return to IDLE. Memory contents are whatever was already written.
- irq is level, deasserted by clear_done or by clearing irq_en.

Test Plan:
- Preload mem[0..7] = 0x100+i; SRC=0, DST=100, LEN=8, start -> mem[100..107] = 0x100..0x107, done at cycle 26, STATUS = 0x2.
- Overlap forward: mem[10..14] = 1..5; SRC=10, DST=12, LEN=5 -> descending copy, mem[12..16] = 1..5, mem[10..11] unchanged.
- Overlap backward: SRC=12, DST=10, LEN=5 with mem[12..16] = A..E -> mem[10..14] = A..E (ascending).
- Boundaries:
  - SRC=8190, LEN=3 -> error=1, done=1, no mem_write pulse.
  - SRC=8191, DST=0, LEN=1 -> mem[0] = mem[8191].
  - LEN=0 -> done in 1 cycle.
- Abort after 2 words of LEN=10 -> STATUS = 0x4, exactly 2 or 3 destination words written, no further chipselect.
- irq_en=1 copy completes -> irq=1. Write clear_done -> irq=0 next cycle. Start while busy and SRC write while busy -> ignored, SRC readback unchanged.
